fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, number of fetched-instruction slots buffered toward decode.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 pcAddr  input  32  current fetch address driven by the PC block.
REQ-005 pcHold  output  1  1 = address not accepted this cycle; PC must hold pcAddr.
REQ-006 flush  input  1  redirect (jump or taken branch); discards all fetched and in-flight work.
REQ-007 memReq  output  1  instruction-memory request, held until memAck.
REQ-008 memAddr  output  32  request address, stable while memReq=1.
REQ-009 memAck  input  1  memory returns memRdata this cycle; valid only while memReq=1.
REQ-010 memRdata  input  32  instruction word returned with memAck.
REQ-011 decReady  input  1  decode consumes the head entry this cycle.
REQ-012 instr  output  32  head instruction; 32'h00000013 (NOP) when instrValid=0.
REQ-013 instrAddr  output  32  address of head instruction; 0 when instrValid=0.
REQ-014 instrValid  output  1  head entry present.
REQ-015 misaligned  output  1  registered: 1 when the accepted pcAddr had bits [1:0] != 0.

Function
REQ-016 FSM states IDLE, WAIT, DROP; encoding from shared package.
REQ-017 accept = (state==IDLE) && (count < FIFO_DEPTH) && !flush; pcHold = !accept (combinational).
REQ-018 On accept: reqAddr <= pcAddr, memReq <= 1, misaligned <= |pcAddr[1:0], state -> WAIT.
REQ-019 memAddr = {reqAddr[31:2], 2'b00}; misaligned requests are still issued.
REQ-020 WAIT, memAck=1, flush=0: push {reqAddr, memRdata}, memReq <= 0, state -> IDLE.
REQ-021 WAIT, memAck=1, flush=1: discard data, memReq <= 0, state -> IDLE.
REQ-022 WAIT, memAck=0, flush=1: state -> DROP, memReq stays 1 (protocol requires hold).
REQ-023 DROP: on memAck discard data, memReq <= 0, state -> IDLE; flush in DROP has no further effect.
REQ-024 Pop when instrValid && decReady; push and pop in the same cycle leave count unchanged.
REQ-025 At most one outstanding request; count never exceeds FIFO_DEPTH; push into a full FIFO cannot occur.
REQ-026 flush: FIFO emptied (count <= 0, pointers reset) at the same edge; instrValid = 0 next cycle; pop ignored that cycle.
REQ-027 Zero-wait memory (memAck in the first memReq cycle): pcAddr accepted in cycle N, memReq high in N+1, instrValid high in N+2.
REQ-028 Sustained throughput with zero-wait memory: one instruction per 2 cycles.
REQ-029 FIFO is in-order; entries are delivered in acceptance order.

Reset
REQ-030 Reset=1 immediately forces state=IDLE, memReq=0, reqAddr=0, count=0, pointers=0, misaligned=0.
REQ-031 During reset, instrValid=0, instr=NOP, instrAddr=0, memAddr=0.
REQ-032 pcHold follows REQ-017 during reset and is therefore 0 unless flush=1.
REQ-033 A memAck arriving during or after a reset that aborted a request is ignored (memReq=0).

Structure
REQ-034 Shared package holds FSM state encoding, NOP constant 32'h00000013, and the default FIFO_DEPTH.
REQ-035 Buffer is the sub-module fetch_fifo (64-bit entries {addr,data}, push/pop/clear, count, full/empty).

Verification
REQ-036 Reset, pcAddr=0x0, zero-wait memory returning 0x00500093 -> memReq high in cycle 1; instrValid=1, instr=0x00500093, instrAddr=0x0 in cycle 2.
REQ-037 decReady=0, pcAddr stepping 0x0, 0x4, 0x8 -> two entries buffered; pcHold=1 with count=2; first pop returns addr 0x0, then 0x4.
REQ-038 memAck delayed 3 cycles, flush pulsed in the 1st WAIT cycle -> state DROP; memReq held until ack; data discarded; instrValid stays 0.
REQ-039 Two entries buffered, flush=1 with decReady=1 -> next cycle instrValid=0, count=0; following accept of pcAddr=0xFFF0 is delivered first.
REQ-040 pcAddr=0xFFF accepted -> memAddr=0xFFC, misaligned=1; next accepted aligned address clears misaligned.
REQ-041 Reset asserted mid-WAIT -> memReq=0 immediately; late memAck produces no entry; fetch restarts from the current pcAddr.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//   DEFAULT_FIFO_DEPTH : default number of fetched-instruction slots toward decode
//   NOP_INSTR          : instruction presented to decode when nothing is valid
//   ST_*               : fetch FSM state encoding
//   fetch_entry_t      : buffered {address, instruction} pair (64 bits)
package fetch_stage_pkg;

    localparam int          DEFAULT_FIFO_DEPTH = 2;
    localparam logic [31:0] NOP_INSTR          = 32'h00000013;

    localparam logic [1:0] ST_IDLE = 2'd0;  // free to accept a new pcAddr
    localparam logic [1:0] ST_WAIT = 2'd1;  // request outstanding, data wanted
    localparam logic [1:0] ST_DROP = 2'd2;  // request outstanding, data unwanted

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of fetched instructions between fetch and decode.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : empties the buffer at the next edge (wins over push/pop)
//   push, push_entry : write one {addr,data} entry at the tail
//   pop           : retire the head entry
//   head          : current head entry (meaningful only when !empty)
//   count, full, empty : occupancy
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            push,
    input  fetch_entry_t    push_entry,
    input  logic            pop,
    output fetch_entry_t    head,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: takes addresses from the PC block, issues one
// instruction-memory request at a time, and buffers returned words for decode.
// Ports:
//   CLK, Reset          : clock, asynchronous active-high reset
//   pcAddr / pcHold     : fetch address in; hold request back to the PC block
//   flush               : redirect; drops buffered and in-flight instructions
//   memReq/memAddr      : request to instruction memory (word aligned)
//   memAck/memRdata     : memory response
//   decReady            : decode consumes the head entry
//   instr/instrAddr/instrValid : head entry toward decode
//   misaligned          : last accepted pcAddr had nonzero low bits
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter  int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] pcAddr,
    output logic        pcHold,
    input  logic        flush,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    input  logic        decReady,
    output logic [31:0] instr,
    output logic [31:0] instrAddr,
    output logic        instrValid,
    output logic        misaligned
);

    logic [1:0]    state_q, state_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic          mem_req_q, mem_req_d;
    logic          misaligned_q, misaligned_d;

    logic          accept;
    logic          fifo_push, fifo_pop;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head, fifo_in;

    // Only IDLE can accept, so there is never more than one request in flight
    // and a free slot at accept time is guaranteed to still be free at push.
    assign accept = (state_q == ST_IDLE) && (fifo_count < CW'(FIFO_DEPTH)) && !flush;
    assign pcHold = !accept;

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        mem_req_d    = mem_req_q;
        misaligned_d = misaligned_q;
        fifo_push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_addr_d   = pcAddr;
                    mem_req_d    = 1'b1;
                    misaligned_d = |pcAddr[1:0];
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (memAck) begin
                    fifo_push = !flush && !fifo_full;
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end else if (flush) begin
                    // Memory protocol forbids withdrawing memReq; sink the ack later.
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (memAck) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            req_addr_q   <= '0;
            mem_req_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            mem_req_q    <= mem_req_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign memReq     = mem_req_q;
    assign memAddr    = {req_addr_q[31:2], 2'b00};
    assign misaligned = misaligned_q;

    assign fifo_in.addr = req_addr_q;
    assign fifo_in.data = memRdata;
    // A flush empties the buffer this edge, so a concurrent pop is meaningless.
    assign fifo_pop     = !fifo_empty && decReady && !flush;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (CLK),
        .rst        (Reset),
        .clear      (flush),
        .push       (fifo_push),
        .push_entry (fifo_in),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign instrValid = !fifo_empty;
    assign instr      = fifo_empty ? NOP_INSTR : fifo_head.data;
    assign instrAddr  = fifo_empty ? 32'h0 : fifo_head.addr;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a memory responder with programmable latency, a
// stepping PC driver, and a scoreboard monitor that expects every accepted
// address to reach decode in order unless a flush or reset discards it.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] pcAddr;
    logic        pcHold;
    logic        flush;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memRdata;
    logic        decReady;
    logic [31:0] instr;
    logic [31:0] instrAddr;
    logic        instrValid;
    logic        misaligned;

    int n_checks = 0;
    int n_errors = 0;

    int   mem_lat;
    int   mem_cnt;
    logic ack_force;
    logic pc_auto;
    logic last_acc = 1'b0;

    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e;

    fetch_stage #(.FIFO_DEPTH(2)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .pcAddr     (pcAddr),
        .pcHold     (pcHold),
        .flush      (flush),
        .memReq     (memReq),
        .memAddr    (memAddr),
        .memAck     (memAck),
        .memRdata   (memRdata),
        .decReady   (decReady),
        .instr      (instr),
        .instrAddr  (instrAddr),
        .instrValid (instrValid),
        .misaligned (misaligned)
    );

    always #5 CLK = ~CLK;

    // Instruction memory image (word addressed).
    function automatic logic [31:0] mem_img(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h00500093;
            32'h0000_0004: return 32'h00A00113;
            32'h0000_0008: return 32'h002081B3;
            32'h0000_0FFC: return 32'h0000A023;
            32'h0000_FFF0: return 32'hFE010113;
            default:       return a ^ 32'h13579BDF;
        endcase
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Memory responder: acks after mem_lat extra cycles of memReq.
    initial begin
        memAck   = 1'b0;
        memRdata = 32'h0;
        mem_cnt  = 0;
        forever begin
            @(posedge CLK);
            #2;
            if (ack_force) begin
                memAck   = 1'b1;
                memRdata = 32'hDEADBEEF;
                mem_cnt  = 0;
            end else if (Reset || !memReq) begin
                memAck  = 1'b0;
                mem_cnt = 0;
            end else if (mem_cnt >= mem_lat) begin
                memAck   = 1'b1;
                memRdata = mem_img(memAddr);
                mem_cnt  = 0;
            end else begin
                memAck = 1'b0;
                mem_cnt++;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge CLK) begin
        last_acc = 1'b0;
        if (Reset) begin
            exp_q.delete();
        end else begin
            if (!instrValid) begin
                chk("idle_instr_nop", instr, NOP_INSTR);
                chk("idle_instrAddr_zero", instrAddr, 32'h0);
            end
            if (instrValid && decReady && !flush) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected_addr", instrAddr, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pop_addr", instrAddr, mon_e.addr);
                    chk("pop_data", instr, mon_e.data);
                end
            end
            if (flush) exp_q.delete();
            if (!pcHold) begin
                mon_e.addr = pcAddr;
                mon_e.data = mem_img({pcAddr[31:2], 2'b00});
                exp_q.push_back(mon_e);
                last_acc = 1'b1;
            end
        end
    end

    task automatic at_neg();
        @(negedge CLK);
        #1;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        if (pc_auto && last_acc) pcAddr = pcAddr + 32'd4;
    endtask

    task automatic restart(input logic [31:0] a, input int lat, input logic dr, input logic au);
        pc_auto = 1'b0;
        Reset   = 1'b1;
        flush   = 1'b0;
        step();
        step();
        pcAddr   = a;
        mem_lat  = lat;
        decReady = dr;
        pc_auto  = au;
        Reset    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; flush = 1'b0; decReady = 1'b0; pcAddr = 32'h0;
        mem_lat = 0; pc_auto = 1'b0; ack_force = 1'b0;

        // Reset state
        step();
        at_neg();
        chk("rst_memReq", memReq, 0);
        chk("rst_instrValid", instrValid, 0);
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_instrAddr", instrAddr, 0);
        chk("rst_memAddr", memAddr, 0);
        chk("rst_misaligned", misaligned, 0);
        chk("rst_pcHold", pcHold, 0);
        step();
        flush = 1'b1;
        at_neg();
        chk("rst_flush_pcHold", pcHold, 1);

        // Zero-wait latency and 1-per-2-cycle throughput
        restart(32'h0, 0, 1'b1, 1'b1);
        at_neg(); chk("t1_c0_pcHold", pcHold, 0); step();
        at_neg();
        chk("t1_c1_memReq", memReq, 1);
        chk("t1_c1_memAddr", memAddr, 32'h0);
        chk("t1_c1_pcHold", pcHold, 1);
        chk("t1_c1_instrValid", instrValid, 0);
        step();
        at_neg();
        chk("t1_c2_instrValid", instrValid, 1);
        chk("t1_c2_instr", instr, 32'h00500093);
        chk("t1_c2_instrAddr", instrAddr, 32'h0);
        step();
        for (int i = 3; i < 8; i++) begin
            at_neg();
            chk("t1_thru_valid", instrValid, (i % 2 == 0) ? 32'd1 : 32'd0);
            step();
        end

        // Two entries buffered with decode stalled
        restart(32'h0, 0, 1'b0, 1'b1);
        step(); step(); step(); step();
        at_neg();
        chk("t2_full_pcHold", pcHold, 1);
        chk("t2_full_instrValid", instrValid, 1);
        chk("t2_full_instrAddr", instrAddr, 32'h0);
        chk("t2_full_memReq", memReq, 0);
        step();
        decReady = 1'b1;
        at_neg();
        chk("t2_pop1_pcHold", pcHold, 1);
        chk("t2_pop1_instrAddr", instrAddr, 32'h0);
        step();
        at_neg();
        chk("t2_pop2_instrAddr", instrAddr, 32'h4);
        chk("t2_pop2_pcHold", pcHold, 0);

        // Flush during a slow request -> DROP
        restart(32'h100, 3, 1'b1, 1'b0);
        at_neg(); chk("t3_c0_pcHold", pcHold, 0); step();
        flush = 1'b1;
        at_neg();
        chk("t3_c1_memReq", memReq, 1);
        chk("t3_c1_pcHold", pcHold, 1);
        step();
        flush = 1'b0;
        at_neg();
        chk("t3_drop_memReq", memReq, 1);
        chk("t3_drop_memAddr", memAddr, 32'h100);
        chk("t3_drop_instrValid", instrValid, 0);
        step();
        flush = 1'b1;
        at_neg();
        chk("t3_c3_memReq", memReq, 1);
        chk("t3_c3_pcHold", pcHold, 1);
        step();
        flush = 1'b0;
        at_neg();
        chk("t3_ack_memReq", memReq, 1);
        chk("t3_ack_pcHold", pcHold, 1);
        chk("t3_ack_instrValid", instrValid, 0);
        step();
        at_neg();
        chk("t3_c5_memReq", memReq, 0);
        chk("t3_c5_instrValid", instrValid, 0);
        chk("t3_c5_pcHold", pcHold, 0);
        step();
        for (int i = 6; i < 10; i++) begin
            at_neg();
            chk("t3_refetch_wait_valid", instrValid, 0);
            step();
        end
        at_neg();
        chk("t3_refetch_valid", instrValid, 1);
        chk("t3_refetch_addr", instrAddr, 32'h100);

        // Flush with two buffered entries, then redirect target first
        restart(32'h40, 0, 1'b0, 1'b1);
        step(); step(); step(); step();
        pc_auto = 1'b0; pcAddr = 32'hFFF0; flush = 1'b1; decReady = 1'b1;
        at_neg();
        chk("t4_pre_instrValid", instrValid, 1);
        chk("t4_pre_instrAddr", instrAddr, 32'h40);
        chk("t4_pre_pcHold", pcHold, 1);
        step();
        flush = 1'b0;
        at_neg();
        chk("t4_post_instrValid", instrValid, 0);
        chk("t4_post_pcHold", pcHold, 0);
        step();
        at_neg();
        chk("t4_req_memAddr", memAddr, 32'hFFF0);
        chk("t4_req_memReq", memReq, 1);
        step();
        at_neg();
        chk("t4_tgt_instrValid", instrValid, 1);
        chk("t4_tgt_instrAddr", instrAddr, 32'hFFF0);
        chk("t4_tgt_instr", instr, 32'hFE010113);

        // Misaligned address
        restart(32'hFFF, 0, 1'b1, 1'b0);
        at_neg(); chk("t5_c0_pcHold", pcHold, 0); step();
        pcAddr = 32'h1000;
        at_neg();
        chk("t5_memAddr", memAddr, 32'hFFC);
        chk("t5_misaligned", misaligned, 1);
        chk("t5_memReq", memReq, 1);
        step();
        at_neg();
        chk("t5_instrValid", instrValid, 1);
        chk("t5_instrAddr", instrAddr, 32'hFFF);
        chk("t5_instr", instr, 32'h0000A023);
        chk("t5_hold_misaligned", misaligned, 1);
        chk("t5_c2_pcHold", pcHold, 0);
        step();
        at_neg();
        chk("t5_clear_misaligned", misaligned, 0);
        chk("t5_next_memAddr", memAddr, 32'h1000);

        // Reset mid-WAIT with a stray late ack
        restart(32'h200, 5, 1'b1, 1'b0);
        at_neg(); chk("t6_c0_pcHold", pcHold, 0); step();
        at_neg(); chk("t6_c1_memReq", memReq, 1); step();
        at_neg(); chk("t6_c2_memAddr", memAddr, 32'h200); step();
        Reset = 1'b1; ack_force = 1'b1;
        #1;
        chk("t6_async_memReq", memReq, 0);
        at_neg();
        chk("t6_rst_memAddr", memAddr, 0);
        chk("t6_rst_instrValid", instrValid, 0);
        chk("t6_rst_pcHold", pcHold, 0);
        step();
        Reset = 1'b0; pcAddr = 32'h300; mem_lat = 0;
        at_neg();
        chk("t6_late_memReq", memReq, 0);
        chk("t6_late_instrValid", instrValid, 0);
        chk("t6_late_pcHold", pcHold, 0);
        step();
        ack_force = 1'b0;
        at_neg();
        chk("t6_restart_memReq", memReq, 1);
        chk("t6_restart_memAddr", memAddr, 32'h300);
        chk("t6_restart_instrValid", instrValid, 0);
        step();
        at_neg();
        chk("t6_restart_valid", instrValid, 1);
        chk("t6_restart_addr", instrAddr, 32'h300);
        chk("t6_restart_instr", instr, 32'h135798DF);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
